// File: rtl/alu_arbiter_pkg.sv
// Shared ALU definitions: aluSel opcodes, highest legal opcode and arbiter FSM states.
package alu_pkg;

  localparam logic [3:0] NOOP = 4'd0;
  localparam logic [3:0] MOV  = 4'd1;
  localparam logic [3:0] NOT  = 4'd2;
  localparam logic [3:0] ADD  = 4'd3;
  localparam logic [3:0] SUB  = 4'd4;
  localparam logic [3:0] OR   = 4'd5;
  localparam logic [3:0] AND  = 4'd6;
  localparam logic [3:0] SLT  = 4'd7;
  localparam logic [3:0] LI   = 4'd8;
  localparam logic [3:0] LUI  = 4'd9;
  localparam logic [3:0] BLT  = 4'd10;
  localparam logic [3:0] BLE  = 4'd11;
  localparam logic [3:0] XOR  = 4'd12;

  localparam logic [3:0] ALU_SEL_MAX = XOR;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  function automatic logic sel_illegal(input logic [3:0] sel);
    return sel > ALU_SEL_MAX;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic [NREQ-1:0] onehot,
  output logic [1:0]      idx,
  output logic            any
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int m = 0; m < NREQ; m++) begin
        if (!any && req[m] && (m == (int'(ptr) + k) % NREQ)) begin
          any       = 1'b1;
          idx       = 2'(m);
          onehot[m] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one ALU among NREQ requesters (IDLE -> EXEC -> RESP).
// Optional ALU_ARB_ILLEGAL_CHK_EN: opcodes above XOR are trapped and answered with rsp_err=1.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_sel,
  input  logic [W*NREQ-1:0] req_a,
  input  logic [W*NREQ-1:0] req_b,
  output logic [3:0]        alu_sel,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  input  logic [W-1:0]      alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_id,
  output logic [W-1:0]      rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err
);

  arb_state_e      state_q;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      id_q;
  logic [3:0]      op_sel_q;
  logic [W-1:0]    op_a_q, op_b_q;
  logic [W-1:0]    rsp_result_q;
  logic            rsp_zero_q;

  logic [NREQ-1:0] pick_onehot;
  logic [1:0]      pick_idx;
  logic            pick_any;
  logic [3:0]      win_sel;
  logic [W-1:0]    win_a, win_b;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req_valid),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    win_sel = '0;
    win_a   = '0;
    win_b   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick_onehot[k]) begin
        win_sel = req_sel[4*k +: 4];
        win_a   = req_a[W*k +: W];
        win_b   = req_b[W*k +: W];
      end
    end
  end

  assign ptr_d     = (int'(pick_idx) == NREQ - 1) ? 2'd0 : pick_idx + 2'd1;
  assign req_ready = (state_q == ST_IDLE) ? pick_onehot : '0;

`ifdef ALU_ARB_ILLEGAL_CHK_EN
  logic illegal_q;
  logic rsp_err_q;
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      id_q         <= '0;
      op_sel_q     <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
      illegal_q    <= 1'b0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            id_q    <= pick_idx;
            ptr_q   <= ptr_d;
            state_q <= ST_EXEC;
            // A trapped opcode leaves the ALU inputs untouched.
`ifdef ALU_ARB_ILLEGAL_CHK_EN
            illegal_q <= sel_illegal(win_sel);
            if (!sel_illegal(win_sel)) begin
`else
            begin
`endif
              op_sel_q <= win_sel;
              op_a_q   <= win_a;
              op_b_q   <= win_b;
            end
          end
        end
        ST_EXEC: begin
`ifdef ALU_ARB_ILLEGAL_CHK_EN
          rsp_result_q <= illegal_q ? '0 : alu_result;
          rsp_zero_q   <= illegal_q | alu_zero;
          rsp_err_q    <= illegal_q;
`else
          rsp_result_q <= alu_result;
          rsp_zero_q   <= alu_zero;
`endif
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign alu_sel    = op_sel_q;
  assign alu_a      = op_a_q;
  assign alu_b      = op_b_q;
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_id     = id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;

endmodule
